// File: rtl/multi_key_debounce.sv
// Multi-channel key debouncer: 2-flop synchronizer, per-channel lockout FSM,
// registered press/release pulses and a saturating long-press detector.
module multi_key_debounce #(
  parameter int CH         = 4,
  parameter int TIME       = 240000,
  parameter int BITS       = 20,
  parameter int HOLD       = 24000000,
  parameter int HBITS      = 25,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic [CH-1:0] key_i,
  output logic [CH-1:0] key_o,
  output logic [CH-1:0] press_o,
  output logic [CH-1:0] release_o,
  output logic [CH-1:0] hold_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam logic IDLE_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic PRESS_LVL = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  localparam logic [BITS-1:0]  LOCK_LAST = BITS'(TIME - 1);
  localparam logic [BITS-1:0]  LOCK_ZERO = {BITS{1'b0}};
  localparam logic [BITS-1:0]  LOCK_ONE  = BITS'(1'b1);
  localparam logic [HBITS-1:0] HOLD_LAST = HBITS'(HOLD - 1);
  localparam logic [HBITS-1:0] HOLD_ZERO = {HBITS{1'b0}};
  localparam logic [HBITS-1:0] HOLD_ONE  = HBITS'(1'b1);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic             meta_r;
    logic             sync_r;
    logic             key_r;
    logic             press_r;
    logic             release_r;
    logic             hold_r;
    logic [0:0]       state_r;
    logic [BITS-1:0]  lock_cnt_r;
    logic [HBITS-1:0] hold_cnt_r;

    logic             key_s;
    logic             press_s;
    logic             release_s;
    logic             hold_s;
    logic [0:0]       state_s;
    logic [BITS-1:0]  lock_cnt_s;
    logic [HBITS-1:0] hold_cnt_s;

    // Two-flop synchronizer on the raw key level
    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        meta_r <= IDLE_LVL;
        sync_r <= IDLE_LVL;
      end else begin
        meta_r <= key_i[g];
        sync_r <= meta_r;
      end
    end

    // Lockout FSM: accept a new level only when idle, then ignore the input for TIME cycles
    always_comb begin
      state_s    = state_r;
      lock_cnt_s = lock_cnt_r;
      key_s      = key_r;
      press_s    = 1'b0;
      release_s  = 1'b0;
      case (state_r)
        ST_IDLE: begin
          lock_cnt_s = LOCK_ZERO;
          if (sync_r != key_r) begin
            key_s     = sync_r;
            state_s   = ST_LOCK;
            press_s   = (sync_r == PRESS_LVL);
            release_s = (sync_r != PRESS_LVL);
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (lock_cnt_r == LOCK_LAST) begin
            state_s    = ST_IDLE;
            lock_cnt_s = LOCK_ZERO;
          end else begin
            lock_cnt_s = lock_cnt_r + LOCK_ONE;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          lock_cnt_s = LOCK_ZERO;
        end
      endcase
    end

    // Long-press tracking; the counter sees the current debounced level, so it lags key_o by one cycle
    always_comb begin
      hold_cnt_s = hold_cnt_r;
      hold_s     = hold_r;
      if (key_r != PRESS_LVL) begin
        hold_cnt_s = HOLD_ZERO;
      end else if (hold_cnt_r != HOLD_LAST) begin
        hold_cnt_s = hold_cnt_r + HOLD_ONE;
      end else begin
        hold_cnt_s = hold_cnt_r;
      end
      if (release_s) begin
        hold_s = 1'b0;
      end else if ((key_r == PRESS_LVL) && (hold_cnt_r == HOLD_LAST)) begin
        hold_s = 1'b1;
      end else begin
        hold_s = hold_r;
      end
    end

    // Channel state and registered outputs
    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        state_r    <= ST_IDLE;
        lock_cnt_r <= LOCK_ZERO;
        hold_cnt_r <= HOLD_ZERO;
        key_r      <= IDLE_LVL;
        press_r    <= 1'b0;
        release_r  <= 1'b0;
        hold_r     <= 1'b0;
      end else begin
        state_r    <= state_s;
        lock_cnt_r <= lock_cnt_s;
        hold_cnt_r <= hold_cnt_s;
        key_r      <= key_s;
        press_r    <= press_s;
        release_r  <= release_s;
        hold_r     <= hold_s;
      end
    end

    assign key_o[g]     = key_r;
    assign press_o[g]   = press_r;
    assign release_o[g] = release_r;
    assign hold_o[g]    = hold_r;
  end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Randomized scoreboard bench for multi_key_debounce; the reference model works
// from per-channel toggle times and press start times rather than FSM state.
module tb_multi_key_debounce;

  localparam int CH    = 2;
  localparam int TIME  = 8;
  localparam int BITS  = 4;
  localparam int HOLD  = 20;
  localparam int HBITS = 5;
  localparam logic PRESS_LVL = 1'b0;
  localparam logic IDLE_LVL  = 1'b1;

  logic          sys_clk;
  logic          rst;
  logic [CH-1:0] key_i;
  logic [CH-1:0] key_o;
  logic [CH-1:0] press_o;
  logic [CH-1:0] release_o;
  logic [CH-1:0] hold_o;

  multi_key_debounce #(
    .CH(CH), .TIME(TIME), .BITS(BITS), .HOLD(HOLD), .HBITS(HBITS), .ACTIVE_LOW(1)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .key_i     (key_i),
    .key_o     (key_o),
    .press_o   (press_o),
    .release_o (release_o),
    .hold_o    (hold_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] k;
    logic [CH-1:0] p;
    logic [CH-1:0] r;
    logic [CH-1:0] h;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: a 2-deep delay of key_i, the debounced level, the cycle of
  // its last change and the cycle the current press became visible.
  logic m_d1[CH];
  logic m_d2[CH];
  logic m_key[CH];
  int   m_last[CH];
  int   m_pstart[CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_d1[c]     = IDLE_LVL;
      m_d2[c]     = IDLE_LVL;
      m_key[c]    = IDLE_LVL;
      m_last[c]   = -1000;
      m_pstart[c] = -1000;
    end
  endfunction

  // One clock cycle: apply the model's view of the edge, drive new inputs, queue the expectation.
  task automatic step(input logic [CH-1:0] nk, input logic nr);
    exp_t e;
    @(posedge sys_clk);
    #1;
    cyc++;
    e.cyc = cyc;
    e.p   = '0;
    e.r   = '0;
    for (int c = 0; c < CH; c++) begin
      if (!rst) begin
        // the previous cycle lies outside the lockout window of the last change
        if ((cyc - 1 >= m_last[c] + TIME) && (m_d2[c] != m_key[c])) begin
          m_key[c]  = m_d2[c];
          m_last[c] = cyc;
          if (m_key[c] == PRESS_LVL) begin
            e.p[c]      = 1'b1;
            m_pstart[c] = cyc;
          end else begin
            e.r[c] = 1'b1;
          end
        end
        m_d2[c] = m_d1[c];
        m_d1[c] = key_i[c];
      end
    end
    key_i = nk;
    rst   = nr;
    if (nr) begin
      model_reset();
      e.p = '0;
      e.r = '0;
    end
    for (int c = 0; c < CH; c++) begin
      e.k[c] = m_key[c];
      e.h[c] = (m_key[c] == PRESS_LVL) && (cyc - m_pstart[c] >= HOLD);
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int at, input logic [CH-1:0] act, input logic [CH-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, at, act, req);
    end
  endtask

  // Monitor: mid-cycle, compare every DUT output against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("key_o",     e.cyc, key_o,     e.k);
        chk("press_o",   e.cyc, press_o,   e.p);
        chk("release_o", e.cyc, release_o, e.r);
        chk("hold_o",    e.cyc, hold_o,    e.h);
      end
    end
  end

  int            run_len[CH];
  logic [CH-1:0] lvl;

  initial begin
    rst   = 1'b1;
    key_i = {CH{IDLE_LVL}};
    model_reset();
    repeat (3) step(2'b11, 1'b1);
    repeat (5) step(2'b11, 1'b0);

    // simultaneous clean press held past HOLD, then ch0 released alone, then ch1
    repeat (40) step(2'b00, 1'b0);
    repeat (20) step(2'b01, 1'b0);
    repeat (20) step(2'b11, 1'b0);

    // bounce on ch0 for 7 cycles settling pressed, then release
    for (int i = 0; i < 7; i++) step((i % 2 == 0) ? 2'b10 : 2'b11, 1'b0);
    repeat (30) step(2'b10, 1'b0);
    repeat (20) step(2'b11, 1'b0);

    // short 2-cycle glitch on ch0
    repeat (2) step(2'b10, 1'b0);
    repeat (25) step(2'b11, 1'b0);

    // reset four cycles into a lockout, key kept pressed across reset exit
    repeat (7) step(2'b10, 1'b0);
    repeat (2) step(2'b10, 1'b1);
    repeat (30) step(2'b10, 1'b0);
    repeat (20) step(2'b11, 1'b0);

    // randomized mix of bouncy and steady levels with rare resets
    lvl = 2'b11;
    for (int c = 0; c < CH; c++) run_len[c] = $urandom_range(1, 30);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (run_len[c] == 0) begin
          lvl[c]     = ~lvl[c];
          run_len[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(5, 45);
        end else begin
          run_len[c] = run_len[c] - 1;
        end
      end
      step(lvl, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    end
    repeat (40) step(2'b11, 1'b0);

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge sys_clk);
    @(negedge sys_clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
